// File: rtl/prefix_decoder_if.sv
// Byte-stream and decoded-instruction signals between the fetch stage,
// the prefix decoder and the downstream instruction decoder.
interface prefix_decoder_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       flush;
    logic       next_instruction;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic       opcode_ready;
    logic       segment_override;
    logic [1:0] override_sr;
    logic [1:0] rep;
    logic       lock;
    logic [3:0] prefix_count;

    // Upstream/downstream environment side.
    modport master (
        output byte_in, byte_valid, flush, next_instruction, opcode_ready,
        input  byte_ready, opcode, opcode_valid, segment_override,
               override_sr, rep, lock, prefix_count
    );

    // Decoder side.
    modport slave (
        input  byte_in, byte_valid, flush, next_instruction, opcode_ready,
        output byte_ready, opcode, opcode_valid, segment_override,
               override_sr, rep, lock, prefix_count
    );
endinterface

// File: rtl/prefix_decoder.sv
// x86-style prefix decoder: gathers segment/REP/LOCK prefixes ahead of the
// opcode byte and presents them together until the instruction retires.
module prefix_decoder #(
    parameter int unsigned MAX_PREFIXES = 14
) (
    input  logic            clk,
    input  logic            reset,
    prefix_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = MAX_PREFIXES[3:0];

    function automatic logic is_segment(input logic [7:0] b);
        case (b)
            8'h26, 8'h2E, 8'h36, 8'h3E: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        case (b)
            8'hF0, 8'hF2, 8'hF3: return 1'b1;
            default:             return is_segment(b);
        endcase
    endfunction

    function automatic logic [1:0] seg_code(input logic [7:0] b);
        case (b)
            8'h2E:   return 2'd1;
            8'h36:   return 2'd2;
            8'h3E:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    state_t     state_p1, state_nx;
    logic [7:0] opcode_p1, opcode_nx;
    logic       vld_p1, vld_nx;
    logic       seg_p1, seg_nx;
    logic [1:0] sr_p1, sr_nx;
    logic [1:0] rep_p1, rep_nx;
    logic       lock_p1, lock_nx;
    logic [3:0] cnt_p1, cnt_nx;
    logic       ready;
    logic       accept;
    logic       clear;

    always_comb begin
        state_nx  = state_p1;
        opcode_nx = opcode_p1;
        seg_nx    = seg_p1;
        sr_nx     = sr_p1;
        rep_nx    = rep_p1;
        lock_nx   = lock_p1;
        cnt_nx    = cnt_p1;
        clear     = 1'b0;
        // Ready is held low while in reset so nothing is handshaken and lost.
        ready     = (state_p1 == COLLECT) && !reset && !bus.flush && !bus.next_instruction;
        accept    = ready && bus.byte_valid;

        if (bus.flush) begin
            clear    = 1'b1;
            state_nx = COLLECT;
        end else begin
            case (state_p1)
                COLLECT: begin
                    if (accept) begin
                        // Once the prefix budget is spent any byte is the opcode.
                        if ((cnt_p1 == MAX_CNT) || !is_prefix(bus.byte_in)) begin
                            opcode_nx = bus.byte_in;
                            state_nx  = PRESENT;
                        end else begin
                            cnt_nx = cnt_p1 + 4'd1;
                            if (is_segment(bus.byte_in)) begin
                                seg_nx = 1'b1;
                                sr_nx  = seg_code(bus.byte_in);
                            end else if (bus.byte_in == 8'hF0) begin
                                lock_nx = 1'b1;
                            end else begin
                                rep_nx = {1'b1, bus.byte_in[0]};
                            end
                        end
                    end
                end
                PRESENT: begin
                    if (bus.opcode_ready) begin
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.next_instruction) begin
                        clear    = 1'b1;
                        state_nx = COLLECT;
                    end
                end
                default: begin
                    clear    = 1'b1;
                    state_nx = COLLECT;
                end
            endcase
        end

        if (clear) begin
            opcode_nx = 8'h00;
            seg_nx    = 1'b0;
            sr_nx     = 2'd0;
            rep_nx    = 2'b00;
            lock_nx   = 1'b0;
            cnt_nx    = 4'd0;
        end

        vld_nx = (state_nx == PRESENT);
    end

    // Stage p1: decoded instruction state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p1  <= COLLECT;
            opcode_p1 <= 8'h00;
            vld_p1    <= 1'b0;
            seg_p1    <= 1'b0;
            sr_p1     <= 2'd0;
            rep_p1    <= 2'b00;
            lock_p1   <= 1'b0;
            cnt_p1    <= 4'd0;
        end else begin
            state_p1  <= state_nx;
            opcode_p1 <= opcode_nx;
            vld_p1    <= vld_nx;
            seg_p1    <= seg_nx;
            sr_p1     <= sr_nx;
            rep_p1    <= rep_nx;
            lock_p1   <= lock_nx;
            cnt_p1    <= cnt_nx;
        end
    end

    assign bus.byte_ready       = ready;
    assign bus.opcode           = opcode_p1;
    assign bus.opcode_valid     = vld_p1;
    assign bus.segment_override = seg_p1;
    assign bus.override_sr      = sr_p1;
    assign bus.rep              = rep_p1;
    assign bus.lock             = lock_p1;
    assign bus.prefix_count     = cnt_p1;

endmodule

// File: tb/tb_prefix_decoder.sv
// Randomized and directed bench for prefix_decoder against a prefix-list
// reference model.
module tb_prefix_decoder;
    localparam int MAX = 14;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    prefix_decoder_if bus();
    prefix_decoder #(.MAX_PREFIXES(MAX)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] pfx_list [7] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF2, 8'hF3};

    // Reference: the instruction is the list of prefixes consumed so far,
    // the opcode, and a phase 0=collecting 1=presenting 2=holding.
    logic [7:0] m_pq[$];
    logic [7:0] m_op;
    int         m_phase;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic is_pfx(input logic [7:0] b);
        foreach (pfx_list[i]) if (pfx_list[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] m_seg();
        logic [2:0] r = 3'b000;
        foreach (m_pq[i])
            if (m_pq[i] >= 8'h26 && m_pq[i] <= 8'h3E && ((m_pq[i] - 8'h26) % 8) == 0)
                r = {1'b1, 2'((m_pq[i] - 8'h26) / 8)};
        return r;
    endfunction

    function automatic logic [1:0] m_rep();
        logic [1:0] r = 2'b00;
        foreach (m_pq[i]) begin
            if (m_pq[i] == 8'hF2) r = 2'b10;
            if (m_pq[i] == 8'hF3) r = 2'b11;
        end
        return r;
    endfunction

    function automatic logic m_lock();
        foreach (m_pq[i]) if (m_pq[i] == 8'hF0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_pq.delete();
        m_op    = 8'h00;
        m_phase = 0;
    endtask

    task automatic compare_all();
        logic [2:0] s;
        s = m_seg();
        chk_eq("byte_ready", bus.byte_ready,
               (m_phase == 0) && !bus.flush && !bus.next_instruction);
        chk_eq("opcode", bus.opcode, m_op);
        chk_eq("opcode_valid", bus.opcode_valid, m_phase == 1);
        chk_eq("segment_override", bus.segment_override, s[2]);
        chk_eq("override_sr", bus.override_sr, s[1:0]);
        chk_eq("rep", bus.rep, m_rep());
        chk_eq("lock", bus.lock, m_lock());
        chk_eq("prefix_count", bus.prefix_count, m_pq.size());
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance the model
    // at the rising edge, return 1 time unit after it with inputs still held.
    task automatic step(input logic bv, input logic [7:0] b, input logic fl,
                        input logic nx, input logic ordy);
        bus.byte_valid       = bv;
        bus.byte_in          = b;
        bus.flush            = fl;
        bus.next_instruction = nx;
        bus.opcode_ready     = ordy;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (fl) model_clear();
        else if (m_phase == 0) begin
            if (bv && !nx) begin
                if (m_pq.size() == MAX || !is_pfx(b)) begin
                    m_op    = b;
                    m_phase = 1;
                end else m_pq.push_back(b);
            end
        end else if (m_phase == 1) begin
            if (ordy) m_phase = 2;
        end else if (nx) model_clear();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk_eq("rst_opcode", bus.opcode, 8'h00);
        chk_eq("rst_opcode_valid", bus.opcode_valid, 1'b0);
        chk_eq("rst_seg", {bus.segment_override, bus.override_sr}, 3'b000);
        chk_eq("rst_rep_lock", {bus.rep, bus.lock}, 3'b000);
        chk_eq("rst_prefix_count", bus.prefix_count, 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        bus.byte_valid = 1'b0; bus.byte_in = 8'h00; bus.flush = 1'b0;
        bus.next_instruction = 1'b0; bus.opcode_ready = 1'b0;
        model_clear();
        @(posedge clk); #1;
        do_reset();
        idle();
        chk_eq("ready_after_reset", bus.byte_ready, 1'b1);

        // 2E,8B with opcode taken immediately
        step(1'b1, 8'h2E, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h8B, 1'b0, 1'b0, 1'b1);
        chk_eq("t1_opcode", bus.opcode, 8'h8B);
        chk_eq("t1_valid", bus.opcode_valid, 1'b1);
        chk_eq("t1_seg", {bus.segment_override, bus.override_sr}, 3'b101);
        chk_eq("t1_count", bus.prefix_count, 4'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk_eq("t1_valid_one_cycle", bus.opcode_valid, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // 26,3E,F3,F0,A4 then retire
        step(1'b1, 8'h26, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h3E, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hF3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
        chk_eq("t2_sr", bus.override_sr, 2'd3);
        chk_eq("t2_rep", bus.rep, 2'b11);
        chk_eq("t2_lock", bus.lock, 1'b1);
        chk_eq("t2_count", bus.prefix_count, 4'd4);
        chk_eq("t2_opcode", bus.opcode, 8'hA4);

        // Downstream stalls for 5 cycles while bytes are offered
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
            chk_eq("t3_valid", bus.opcode_valid, 1'b1);
            chk_eq("t3_opcode", bus.opcode, 8'hA4);
            chk_eq("t3_prefixes", {bus.override_sr, bus.rep, bus.lock}, 5'b11111);
            chk_eq("t3_ready", bus.byte_ready, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk_eq("t2_cleared", {bus.opcode, bus.segment_override, bus.rep, bus.lock, bus.prefix_count}, 16'h0);
        idle();
        chk_eq("t2_ready", bus.byte_ready, 1'b1);

        // Prefix budget exhausted: fifteenth 36 becomes the opcode
        for (int i = 0; i < 15; i++) step(1'b1, 8'h36, 1'b0, 1'b0, 1'b0);
        chk_eq("t4_count", bus.prefix_count, 4'd14);
        chk_eq("t4_opcode", bus.opcode, 8'h36);
        chk_eq("t4_valid", bus.opcode_valid, 1'b1);

        // Flush coinciding with next_instruction in HOLD
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        chk_eq("t5_flush", {bus.opcode, bus.opcode_valid, bus.segment_override,
                            bus.override_sr, bus.rep, bus.lock, bus.prefix_count}, 19'h0);

        // Reset after a segment prefix leaves no stale override
        step(1'b1, 8'h2E, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h8B, 1'b0, 1'b0, 1'b0);
        chk_eq("t6_opcode", bus.opcode, 8'h8B);
        chk_eq("t6_seg", {bus.segment_override, bus.override_sr}, 3'b000);
        chk_eq("t6_count", bus.prefix_count, 4'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] b;
            if ($urandom_range(0, 1) == 0) b = pfx_list[$urandom_range(0, 6)];
            else b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 9) < 7, b, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 9) < 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prefix_decoder.md
PREFIX_DECODER -- requirements
Module: prefix_decoder

Interface
REQ-001 SHALL have parameter MAX_PREFIXES, default 14, meaning the prefix-byte limit per instruction.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port byte_in  input  8  next instruction-stream byte.
REQ-005 SHALL have port byte_valid  input  1  byte_in valid.
REQ-006 SHALL have port byte_ready  output  1  byte accepted when byte_valid && byte_ready.
REQ-007 SHALL have port flush  input  1  discard all state (branch/interrupt).
REQ-008 SHALL have port next_instruction  input  1  downstream finished current instruction.
REQ-009 SHALL have port opcode  output  8  first non-prefix byte.
REQ-010 SHALL have port opcode_valid  output  1  opcode and prefix outputs valid.
REQ-011 SHALL have port opcode_ready  input  1  downstream accepts opcode.
REQ-012 SHALL have port segment_override  output  1  a segment prefix was seen.
REQ-013 SHALL have port override_sr  output  2  ES=0, CS=1, SS=2, DS=3.
REQ-014 SHALL have port rep  output  2  00 none, 10 REPNE (F2), 11 REP/REPE (F3).
REQ-015 SHALL have port lock  output  1  LOCK (F0) seen.
REQ-016 SHALL have port prefix_count  output  4  prefix bytes consumed for the current instruction.

Function
REQ-017 SHALL implement states COLLECT, PRESENT, HOLD.
REQ-018 byte_ready SHALL be 1 only in COLLECT with flush=0 and next_instruction=0.
REQ-019 In COLLECT, an accepted 26/2E/36/3E SHALL set segment_override=1 and override_sr=0/1/2/3; the last segment prefix wins.
REQ-020 In COLLECT, an accepted F2/F3 SHALL set rep to 10/11; the last wins. F0 SHALL set lock (sticky).
REQ-021 Each accepted prefix SHALL increment prefix_count.
REQ-022 An accepted non-prefix byte SHALL be registered into opcode, with the state moving to PRESENT; opcode_valid=1 the following cycle (1-cycle latency).
REQ-023 When prefix_count equals MAX_PREFIXES, the next accepted byte SHALL be treated as the opcode regardless of value; the counter SHALL never wrap.
REQ-024 In PRESENT, opcode_valid=1. opcode, opcode_valid and the prefix outputs SHALL hold stable until opcode_ready=1, then the state moves to HOLD with opcode_valid=0 the next cycle.
REQ-025 In HOLD, the prefix outputs SHALL remain stable; no bytes are accepted.
REQ-026 next_instruction in HOLD SHALL clear all prefix outputs, prefix_count and opcode, and return to COLLECT next cycle.
REQ-027 next_instruction in COLLECT or PRESENT SHALL be ignored.
REQ-028 flush SHALL, from any state, clear all outputs to reset values and enter COLLECT next cycle; the byte offered that cycle is not consumed.
REQ-029 If flush and next_instruction coincide, flush SHALL take priority; the result is the same state for either order.
REQ-030 If opcode_ready and flush coincide in PRESENT, flush SHALL win; the opcode is dropped.
REQ-031 byte_valid=0 in COLLECT SHALL leave all state unchanged.

Reset
REQ-032 reset SHALL asynchronously force COLLECT, opcode=00, opcode_valid=0, segment_override=0, override_sr=0, rep=00, lock=0 and prefix_count=0; byte_ready SHALL rise the first cycle after reset deasserts.
REQ-033 Reset mid-instruction SHALL discard any partial prefixes and any presented opcode.

Verification
REQ-034 Stream 2E,8B with opcode_ready=1 -> opcode=8B, segment_override=1, override_sr=1, prefix_count=1; opcode_valid high exactly one cycle.
REQ-035 Stream 26,3E,F3,F0,A4 -> override_sr=3, rep=11, lock=1, prefix_count=4; next_instruction then clears all and byte_ready=1.
REQ-036 opcode_ready held 0 for 5 cycles with byte_valid=1 -> opcode_valid and prefixes stable, byte_ready=0 throughout.
REQ-037 Fifteen 36 bytes with MAX_PREFIXES=14 -> prefix_count=14, opcode=36.
REQ-038 flush asserted with next_instruction in HOLD, and separately reset asserted mid-prefix (after 2E) -> all outputs at reset values, no stale override on the following 8B.
